clk_gate_ctrl: RTL and testbench

- Multi-channel clock-gating controller. Generates one registered, glitch-free gate enable per channel, driving that channel's ICG cell in the gating wrapper.
- Each channel runs a wake/idle state machine with three features:
  - request/acknowledge handshake;
  - programmable clock-settle delay before ACK;
  - programmable idle timeout before the clock is gated off.
- Sits between block-level activity signals and the ICG cells of the clock tree.

---
 rtl/clk_gate_ctrl.sv | 105 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel wake/idle FSM driving a
// registered, glitch-free ICG enable with REQ/ACK handshake and idle timeout.
module clk_gate_ctrl #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned IDLE_W   = 8,
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned CNT_W    = $clog2(NUM_CH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TE,
    input  logic [NUM_CH-1:0] REQ,
    input  logic [NUM_CH-1:0] BUSY,
    input  logic [IDLE_W-1:0] IDLE_CFG,
    output logic [NUM_CH-1:0] ACK,
    output logic [NUM_CH-1:0] EN_GATE,
    output logic [CNT_W-1:0]  ACTIVE_CNT
);

    localparam int unsigned WK_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2
    } state_t;

    state_t            state_q  [NUM_CH];
    logic [WK_W-1:0]   wake_cnt [NUM_CH];
    logic [IDLE_W-1:0] idle_cnt [NUM_CH];
    logic [NUM_CH-1:0] en_reg;
    logic [NUM_CH-1:0] active_nxt;
    logic [CNT_W-1:0]  active_sum;

    // Which channels will be out of OFF after this edge, so the count tracks the states
    always_comb begin
        active_nxt = '0;
        active_sum = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            case (state_q[i])
                ST_OFF:  active_nxt[i] = REQ[i];
                ST_WAKE: active_nxt[i] = 1'b1;
                ST_ON:   active_nxt[i] = REQ[i] | BUSY[i] | (idle_cnt[i] != '0);
                default: active_nxt[i] = 1'b0;
            endcase
            active_sum = active_sum + CNT_W'(active_nxt[i]);
        end
    end

    // Per-channel wake/idle state machines with registered enable and ACK
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i]  <= ST_OFF;
                wake_cnt[i] <= '0;
                idle_cnt[i] <= '0;
            end
            en_reg     <= '0;
            ACK        <= '0;
            ACTIVE_CNT <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                case (state_q[i])
                    ST_OFF: begin
                        if (REQ[i]) begin
                            state_q[i]  <= ST_WAKE;
                            en_reg[i]   <= 1'b1;
                            wake_cnt[i] <= WK_W'(WAKE_CYC - 1);
                        end
                    end
                    ST_WAKE: begin
                        if (wake_cnt[i] == '0) begin
                            state_q[i]  <= ST_ON;
                            ACK[i]      <= 1'b1;
                            idle_cnt[i] <= IDLE_CFG;
                        end else begin
                            wake_cnt[i] <= wake_cnt[i] - WK_W'(1);
                        end
                    end
                    ST_ON: begin
                        if (REQ[i] | BUSY[i]) begin
                            idle_cnt[i] <= IDLE_CFG;
                        end else if (idle_cnt[i] == '0) begin
                            state_q[i] <= ST_OFF;
                            en_reg[i]  <= 1'b0;
                            ACK[i]     <= 1'b0;
                        end else begin
                            idle_cnt[i] <= idle_cnt[i] - IDLE_W'(1);
                        end
                    end
                    default: begin
                        state_q[i] <= ST_OFF;
                        en_reg[i]  <= 1'b0;
                        ACK[i]     <= 1'b0;
                    end
                endcase
            end
            ACTIVE_CNT <= active_sum;
        end
    end

    // Only combinational path: test enable overrides the flopped enable
    assign EN_GATE = en_reg | {NUM_CH{TE}};

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Testbench for clk_gate_ctrl: directed handshake/timeout cases plus random
// traffic, checked every cycle against a deadline-based reference model.
module tb_clk_gate_ctrl;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned IDLE_W   = 8;
    localparam int unsigned WAKE_CYC = 2;
    localparam int unsigned CNT_W    = $clog2(NUM_CH + 1);

    logic              CLK = 1'b0;
    logic              RST;
    logic              TE;
    logic [NUM_CH-1:0] REQ;
    logic [NUM_CH-1:0] BUSY;
    logic [IDLE_W-1:0] IDLE_CFG;
    logic [NUM_CH-1:0] ACK;
    logic [NUM_CH-1:0] EN_GATE;
    logic [CNT_W-1:0]  ACTIVE_CNT;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: channel is "active" from wake request until its idle
    // deadline passes; ACK rises at a fixed edge after the request.
    bit act  [NUM_CH];
    bit ackd [NUM_CH];
    int ack_at [NUM_CH];
    int off_at [NUM_CH];
    int t = 0;

    clk_gate_ctrl #(
        .NUM_CH  (NUM_CH),
        .IDLE_W  (IDLE_W),
        .WAKE_CYC(WAKE_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .TE        (TE),
        .REQ       (REQ),
        .BUSY      (BUSY),
        .IDLE_CFG  (IDLE_CFG),
        .ACK       (ACK),
        .EN_GATE   (EN_GATE),
        .ACTIVE_CNT(ACTIVE_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (RST) begin
                act[i]  = 1'b0;
                ackd[i] = 1'b0;
            end else if (!act[i]) begin
                if (REQ[i]) begin
                    act[i]    = 1'b1;
                    ack_at[i] = t + int'(WAKE_CYC);
                end
            end else if (!ackd[i]) begin
                if (t == ack_at[i]) begin
                    ackd[i]   = 1'b1;
                    off_at[i] = t + int'(IDLE_CFG) + 1;
                end
            end else if (REQ[i] || BUSY[i]) begin
                off_at[i] = t + int'(IDLE_CFG) + 1;
            end else if (t >= off_at[i]) begin
                act[i]  = 1'b0;
                ackd[i] = 1'b0;
            end
        end
    endtask

    // One clock edge: advance the model, then compare on the falling edge
    task automatic step();
        logic [NUM_CH-1:0] e_en;
        logic [NUM_CH-1:0] e_ack;
        int                e_cnt;
        @(posedge CLK);
        t++;
        model_edge();
        @(negedge CLK);
        e_en  = '0;
        e_ack = '0;
        e_cnt = 0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            e_en[i]  = act[i];
            e_ack[i] = ackd[i];
            e_cnt    = e_cnt + (act[i] ? 1 : 0);
        end
        chk("en_gate", 32'(EN_GATE), 32'(e_en | {NUM_CH{TE}}));
        chk("ack", 32'(ACK), 32'(e_ack));
        chk("active_cnt", 32'(ACTIVE_CNT), 32'(e_cnt));
    endtask

    task automatic settle_off(input int cyc);
        REQ  = '0;
        BUSY = '0;
        repeat (cyc) step();
    endtask

    initial begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            act[i] = 0; ackd[i] = 0; ack_at[i] = 0; off_at[i] = 0;
        end
        RST = 1'b1; TE = 1'b0; REQ = '0; BUSY = '0; IDLE_CFG = 8'd5;
        step(); step();
        RST = 1'b0;
        repeat (20) step();

        // Test enable forces every gate open without touching the FSMs
        TE = 1'b1;
        #1;
        chk("te_force_en", 32'(EN_GATE), 32'hF);
        chk("te_force_ack", 32'(ACK), 32'h0);
        chk("te_force_cnt", 32'(ACTIVE_CNT), 32'h0);
        step();
        TE = 1'b0;

        // Wake latency on channel 1
        REQ = 4'b0010;
        step();
        chk("wake_en_n", 32'(EN_GATE), 32'h2);
        chk("wake_ack_n", 32'(ACK), 32'h0);
        chk("wake_cnt_n", 32'(ACTIVE_CNT), 32'h1);
        step();
        chk("wake_ack_n1", 32'(ACK), 32'h0);
        step();
        chk("wake_ack_n2", 32'(ACK), 32'h2);

        // Idle timeout of 5: off exactly 5 edges after the first idle edge
        step();
        REQ = '0;
        repeat (5) step();
        chk("idle5_still_on", 32'(EN_GATE[1]), 32'h1);
        step();
        chk("idle5_off_en", 32'(EN_GATE[1]), 32'h0);
        chk("idle5_off_ack", 32'(ACK[1]), 32'h0);

        // BUSY pulse at idle edge m+3 reloads: off at m+3+C+1
        REQ = 4'b0010;
        repeat (4) step();
        REQ = '0;
        repeat (3) step();
        BUSY = 4'b0010;
        step();
        BUSY = '0;
        repeat (5) step();
        chk("busy_still_on", 32'(EN_GATE[1]), 32'h1);
        step();
        chk("busy_off", 32'(EN_GATE[1]), 32'h0);

        // IDLE_CFG=0: gate-off at the first idle edge
        IDLE_CFG = 8'd0;
        REQ = 4'b0010;
        repeat (4) step();
        REQ = '0;
        step();
        chk("cfg0_off", 32'(EN_GATE[1]), 32'h0);

        // REQ back exactly when the idle count reaches zero: stays ON
        IDLE_CFG = 8'd2;
        REQ = 4'b0010;
        repeat (4) step();
        REQ = '0;
        step(); step();
        REQ = 4'b0010;
        step();
        chk("rearm_zero_ack", 32'(ACK[1]), 32'h1);
        chk("rearm_zero_en", 32'(EN_GATE[1]), 32'h1);

        // One-cycle REQ pulse from OFF: full wake, then IDLE_CFG timeout
        IDLE_CFG = 8'd3;
        settle_off(10);
        REQ = 4'b0010;
        step();
        REQ = '0;
        step();
        chk("pulse_ack_early", 32'(ACK[1]), 32'h0);
        step();
        chk("pulse_ack", 32'(ACK[1]), 32'h1);
        repeat (3) step();
        chk("pulse_still_on", 32'(EN_GATE[1]), 32'h1);
        step();
        chk("pulse_off", 32'(EN_GATE[1]), 32'h0);

        // All channels together
        settle_off(10);
        REQ = 4'hF;
        step();
        chk("all_cnt", 32'(ACTIVE_CNT), 32'h4);
        step(); step();
        chk("all_ack", 32'(ACK), 32'hF);

        // Reset with channels in both WAKE and ON
        settle_off(10);
        REQ = 4'b0011;
        repeat (3) step();
        REQ = 4'b1111;
        step();
        RST = 1'b1;
        step();
        chk("rst_en", 32'(EN_GATE), 32'h0);
        chk("rst_ack", 32'(ACK), 32'h0);
        chk("rst_cnt", 32'(ACTIVE_CNT), 32'h0);
        RST = 1'b0;
        REQ = '0;
        repeat (5) step();
        chk("rst_no_ack", 32'(ACK), 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                REQ[i]  = ($urandom_range(0, 5) == 0);
                BUSY[i] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 15) == 0) IDLE_CFG = IDLE_W'($urandom_range(0, 7));
            TE  = ($urandom_range(0, 31) == 0);
            RST = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
